spi_xfer_queue: RTL
===================

# spi_xfer_queue

Transaction queue that sits directly upstream of the SPI master and feeds its host-side control port. Software-side logic pushes TX words into a TX FIFO. The block launches one SPI transfer per word using a start pulse and data word, waits for the master's done pulse, and pushes the returned word into an RX FIFO. It provides buffering and backpressure, a watchdog on stuck transfers, and a single in-flight transaction at any time.

## Interface
Parameters:
- DATA_LENGTH, default 8: SPI word width; must match the master.
- DEPTH, default 4: entries per FIFO; power of two, ≥2.
- TIMEOUT, default 1024: maximum cycles in WAIT before abort; ≥2.

Ports:
- clk, in, 1: system clock; all logic on its rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: launch enable; while low, no new transfer starts.
- wr_valid, in, 1: TX push request.
- wr_data, in, DATA_LENGTH: TX word.
- wr_ready, out, 1: TX FIFO not full.
- rd_valid, out, 1: RX FIFO not empty.
- rd_data, out, DATA_LENGTH: RX head word; valid when rd_valid=1.
- rd_ready, in, 1: RX pop request.
- m_start, out, 1: to master start; one-cycle pulse.
- m_data_in, out, DATA_LENGTH: to master data_in.
- m_done, in, 1: from master done; one-cycle pulse.
- m_data_out, in, DATA_LENGTH: from master data_out; valid while m_done=1.
- tx_count, out, $clog2(DEPTH)+1: TX occupancy.
- rx_count, out, $clog2(DEPTH)+1: RX occupancy.
- idle, out, 1: FSM in IDLE and tx_count==0.
- err, out, 1: sticky timeout flag.
- err_clr, in, 1: clears err.

## Operation
- FIFOs are circular buffers with read/write pointers and a count.
  - Push occurs when wr_valid && wr_ready. wr_ready = (tx_count != DEPTH) and is derived from registered count only; a pop in the same cycle does not raise it.
  - Pop occurs when rd_ready && rd_valid. rd_ready while empty is ignored.
  - A simultaneous push and pop on the same FIFO leaves its count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE → LAUNCH when en && tx_count != 0 && rx_count != DEPTH. The RX slot is reserved at launch, so a returned word is never dropped. On this edge, m_data_in is loaded from the TX head.
  - LAUNCH lasts exactly 1 cycle with m_start=1. The TX head is popped at the end of LAUNCH. LAUNCH → WAIT unconditionally; the timeout counter clears.
  - In WAIT, when m_done=1, m_data_out is written into RX at that edge and the FSM goes to IDLE.
  - In WAIT, if the timeout counter reaches TIMEOUT-1 with no m_done, the FSM sets err=1 and goes to IDLE. The word is lost and nothing is written to RX.
- m_done outside WAIT is ignored.
- m_data_in holds its value until the next launch.
- err is set by a timeout and cleared by err_clr. If both occur in the same cycle, set wins.
- en dropping during LAUNCH or WAIT does not abort the in-flight transfer.
- Reset values: m_start=0, m_data_in=0, wr_ready=1, rd_valid=0, tx_count=0, rx_count=0, idle=1, err=0, FSM=IDLE, pointers=0. rd_data is don't-care while empty.
- Reset mid-transfer empties both FIFOs and returns the FSM to IDLE immediately. The master is reset by the same rst_n.

## Timing
- Push at edge N sets tx_count=1 after N.
  - If idle and en=1, LAUNCH occurs at cycle N+1→N+2.
  - m_start is high during cycle N+2, and tx_count decrements after that cycle.
- The master samples start and data_in in that same cycle.
- The RX word is visible on rd_valid/rd_data the cycle after the m_done cycle.
- Back-to-back transfers: the next m_start is asserted no earlier than 2 cycles after m_done.
- The minimum gap between m_start pulses is 3 cycles plus the master transfer time.
- All outputs are registered, except rd_data (RAM read at the head pointer) and idle (decode of registered state).

## Test plan
- Single word: push 0xA5 with the master model returning 0x3C 20 cycles after start → exactly one m_start pulse with m_data_in=0xA5; rd_data=0x3C, rx_count=1; idle=1 afterwards.
- Burst/full: with en=0, push 0x01..0x05 → wr_ready drops after the 4th push and the 5th push is not accepted; set en=1 → four ordered transfers with data_in 0x01..0x04; RX returns them in order.
- RX backpressure: fill RX to 4 entries, keep one word in TX → no m_start; pop one RX word → exactly one launch follows.
- Timeout: push 0x77 with the model never pulsing done → err=1 at start+TIMEOUT cycles, FSM returns to IDLE, rx_count stays 0; a late m_done is ignored; err_clr clears err.
- Simultaneous: push to TX while a transfer completes and RX is popped in the same cycle → counts stay correct; no loss or duplication over 100 random cycles versus a scoreboard.
- Reset in WAIT: assert rst_n=0 mid-transfer → all outputs return to their reset values asynchronously; after release, a new push transfers normally.

Source files
------------

// File: rtl/spi_xfer_queue.sv
`default_nettype none
// ============================================================================
// spi_xfer_queue : TX/RX FIFO pair feeding an SPI master, one transfer in flight
// Revision 1.0
// ============================================================================
module spi_xfer_queue #(
  parameter int DATA_LENGTH = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   wr_valid,
  input  logic [DATA_LENGTH-1:0] wr_data,
  output logic                   wr_ready,
  output logic                   rd_valid,
  output logic [DATA_LENGTH-1:0] rd_data,
  input  logic                   rd_ready,
  output logic                   m_start,
  output logic [DATA_LENGTH-1:0] m_data_in,
  input  logic                   m_done,
  input  logic [DATA_LENGTH-1:0] m_data_out,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   idle,
  output logic                   err,
  input  logic                   err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [DATA_LENGTH-1:0] tx_mem_q [DEPTH];
  logic [DATA_LENGTH-1:0] rx_mem_q [DEPTH];
  logic [PW-1:0]          tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [CW-1:0]          tx_count_q, rx_count_q;
  logic                   err_q;
  logic                   m_start_q;
  logic [DATA_LENGTH-1:0] m_data_in_q;

  logic tx_push, tx_pop, rx_push, rx_pop;
  logic launch, timeout;

  assign wr_ready  = (tx_count_q != FULL);
  assign rd_valid  = (rx_count_q != '0);
  assign rd_data   = rx_mem_q[rx_rptr_q];
  assign idle      = (state_q == IDLE) && (tx_count_q == '0);
  assign err       = err_q;
  assign m_start   = m_start_q;
  assign m_data_in = m_data_in_q;
  assign tx_count  = tx_count_q;
  assign rx_count  = rx_count_q;

  assign tx_push = wr_valid && wr_ready;
  assign rx_pop  = rd_ready && rd_valid;

  // Launch requires a free RX slot; only this FSM fills RX, so the slot stays reserved.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    launch  = 1'b0;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && (tx_count_q != '0) && (rx_count_q != FULL)) begin
          launch  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_pop  = 1'b1;
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (m_done) begin
          rx_push = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      err_q       <= 1'b0;
      m_start_q   <= 1'b0;
      m_data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      m_start_q <= launch;
      if (launch)  m_data_in_q <= tx_mem_q[tx_rptr_q];
      if (tx_push) tx_wptr_q   <= tx_wptr_q + PW'(1);
      if (tx_pop)  tx_rptr_q   <= tx_rptr_q + PW'(1);
      if (rx_push) rx_wptr_q   <= rx_wptr_q + PW'(1);
      if (rx_pop)  rx_rptr_q   <= rx_rptr_q + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count_q <= tx_count_q + CW'(1);
        2'b01:   tx_count_q <= tx_count_q - CW'(1);
        default: tx_count_q <= tx_count_q;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_count_q <= rx_count_q + CW'(1);
        2'b01:   rx_count_q <= rx_count_q - CW'(1);
        default: rx_count_q <= rx_count_q;
      endcase
      if (timeout)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= wr_data;
    if (rx_push) rx_mem_q[rx_wptr_q] <= m_data_out;
  end

endmodule
`default_nettype wire
